// File: rtl/gamepad_poller.sv
// gamepad_poller
// Reads NES/SNES-style serial controllers over a shared latch and data clock.
// A poll is a latch pulse followed by NUM_BITS low/high clock phases; the
// captured word is published all at once, with a per-pad "changed" flag.
module gamepad_poller #(
    parameter int NUM_PADS     = 2,
    parameter int NUM_BITS     = 8,
    parameter int LATCH_CYCLES = 324,
    parameter int HALF_CYCLES  = 162,
    parameter int POLL_CYCLES  = 450000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_poll_en,
    input  logic                         i_trigger,
    output logic                         o_data_latch,
    output logic                         o_data_clock,
    input  logic [NUM_PADS-1:0]          i_serial_data,
    output logic [NUM_PADS*NUM_BITS-1:0] o_button_state,
    output logic                         o_data_available,
    output logic [NUM_PADS-1:0]          o_changed
);

    localparam int MAX_PHASE = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);
    localparam int BIT_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int TIMER_W   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int WORD_W    = NUM_PADS * NUM_BITS;

    // The poll period must leave room for a complete poll plus the return to idle.
    if (POLL_CYCLES <= LATCH_CYCLES + 2 * NUM_BITS * HALF_CYCLES + 2) begin : g_cfg_check
        $error("gamepad_poller: POLL_CYCLES too short for one complete poll");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic                 timer_wrap;
    logic                 start_d;
    logic [WORD_W-1:0]    shadow_q;
    logic [WORD_W-1:0]    button_q;
    logic                 latch_q;
    logic                 dclk_q;
    logic                 avail_q;
    logic [NUM_PADS-1:0]  changed_q;

    assign timer_wrap = (timer_q == TIMER_W'(POLL_CYCLES - 1));
    assign timer_d    = timer_wrap ? '0 : timer_q + TIMER_W'(1);
    // A start request is only acted on in IDLE; elsewhere it is simply ignored.
    assign start_d    = i_trigger | (timer_wrap & i_poll_en);

    // Free-running poll timer, independent of the poll state machine.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Poll sequencer: drives latch/clock, samples pads, publishes the word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shadow_q  <= '0;
            button_q  <= '0;
            latch_q   <= 1'b0;
            dclk_q    <= 1'b0;
            avail_q   <= 1'b0;
            changed_q <= '0;
        end else begin
            avail_q   <= 1'b0;
            changed_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q <= S_LATCH;
                        latch_q <= 1'b1;
                        cnt_q   <= CNT_W'(LATCH_CYCLES - 1);
                    end
                end
                S_LATCH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_LOW;
                        latch_q <= 1'b0;
                        bit_q   <= '0;
                        cnt_q   <= CNT_W'(HALF_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (cnt_q == '0) begin
                        // Pads drive active-low data; store as pressed=1.
                        for (int p = 0; p < NUM_PADS; p++) begin
                            shadow_q[p*NUM_BITS + int'(bit_q)] <= ~i_serial_data[p];
                        end
                        if (bit_q == BIT_W'(NUM_BITS - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_HIGH;
                            dclk_q  <= 1'b1;
                            cnt_q   <= CNT_W'(HALF_CYCLES - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_LOW;
                        dclk_q  <= 1'b0;
                        bit_q   <= bit_q + BIT_W'(1);
                        cnt_q   <= CNT_W'(HALF_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    button_q <= shadow_q;
                    avail_q  <= 1'b1;
                    for (int p = 0; p < NUM_PADS; p++) begin
                        changed_q[p] <= (shadow_q[p*NUM_BITS +: NUM_BITS] !=
                                         button_q[p*NUM_BITS +: NUM_BITS]);
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    latch_q <= 1'b0;
                    dclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_latch     = latch_q;
    assign o_data_clock     = dclk_q;
    assign o_button_state   = button_q;
    assign o_data_available = avail_q;
    assign o_changed        = changed_q;

endmodule

// File: tb/tb_gamepad_poller.sv
// Testbench for gamepad_poller: two instances (2x8-bit and 1x16-bit pads)
// driven by behavioural shift-register controller models.
module tb_gamepad_poller;

    localparam int LC = 8;
    localparam int HC = 4;
    localparam int PC = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, poll_en, trig;
    logic        latch_a, dclk_a, avail_a;
    logic [1:0]  serial_a, chg_a;
    logic [15:0] state_a;

    logic        trig_b, latch_b, dclk_b, avail_b;
    logic [0:0]  serial_b, chg_b;
    logic [15:0] state_b;

    logic [7:0]  btn_a [2];
    logic [15:0] btn_b;
    int          idx_a = 0;
    int          idx_b = 0;

    gamepad_poller #(
        .NUM_PADS(2), .NUM_BITS(8), .LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_poll_en(poll_en), .i_trigger(trig),
        .o_data_latch(latch_a), .o_data_clock(dclk_a), .i_serial_data(serial_a),
        .o_button_state(state_a), .o_data_available(avail_a), .o_changed(chg_a)
    );

    gamepad_poller #(
        .NUM_PADS(1), .NUM_BITS(16), .LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_poll_en(1'b0), .i_trigger(trig_b),
        .o_data_latch(latch_b), .o_data_clock(dclk_b), .i_serial_data(serial_b),
        .o_button_state(state_b), .o_data_available(avail_b), .o_changed(chg_b)
    );

    // Controller models: latch reloads bit 0, each data-clock rise shifts one bit.
    initial forever begin
        @(posedge latch_a or posedge dclk_a);
        if (latch_a) idx_a = 0; else idx_a = idx_a + 1;
    end
    initial forever begin
        @(posedge latch_b or posedge dclk_b);
        if (latch_b) idx_b = 0; else idx_b = idx_b + 1;
    end
    always_comb begin
        serial_a = 2'b11;
        for (int p = 0; p < 2; p++) begin
            if (idx_a < 8) serial_a[p] = ~btn_a[p][idx_a[2:0]];
        end
    end
    always_comb begin
        serial_b = 1'b1;
        if (idx_b < 16) serial_b[0] = ~btn_b[idx_b[3:0]];
    end

    int n_chk = 0;
    int n_fail = 0;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
        end
    endfunction

    typedef struct {
        logic [15:0] st;
        logic [1:0]  chg;
    } exp_t;

    typedef struct {
        logic [7:0]  pad0;
        logic [7:0]  pad1;
        logic [15:0] st;
        logic [1:0]  chg;
    } vec_t;

    exp_t sb[$];
    int   rise_log[$];
    int   avail_log[$];
    int   cyc = 0;
    int   rise_a = 0, llen_a = 0, pulses_a = 0, chi_a = 0;
    logic lp_a = 1'b0, cp_a = 1'b0;

    // Monitor for instance A: waveform shape, scoreboard pop on each publish.
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (latch_a && !lp_a) begin
            rise_a = cyc; llen_a = 0; pulses_a = 0; chi_a = 0;
            rise_log.push_back(cyc);
        end
        if (latch_a) llen_a++;
        if (dclk_a && !cp_a) pulses_a++;
        if (dclk_a) chi_a++;
        chk("a_latch_clock_overlap", {31'b0, latch_a & dclk_a}, 32'd0);
        if (avail_a) begin
            avail_log.push_back(cyc);
            if (sb.size() == 0) begin
                chk("a_unexpected_available", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("a_button_state", {16'b0, state_a}, {16'b0, e.st});
                chk("a_changed", {30'b0, chg_a}, {30'b0, e.chg});
                chk("a_latency", cyc - rise_a, 32'd69);
                chk("a_latch_len", llen_a, LC);
                chk("a_clock_pulses", pulses_a, 32'd7);
                chk("a_clock_high_cycles", chi_a, 32'd28);
            end
        end else begin
            chk("a_changed_idle", {30'b0, chg_a}, 32'd0);
        end
        lp_a = latch_a;
        cp_a = dclk_a;
    end

    int   rise_b = 0, pulses_b = 0;
    logic lp_b = 1'b0, cp_b = 1'b0;
    int   avb_lat = -1;

    // Monitor for instance B: clock pulse count and latency.
    initial forever begin
        @(negedge clk);
        if (latch_b && !lp_b) begin rise_b = cyc; pulses_b = 0; end
        if (dclk_b && !cp_b) pulses_b++;
        chk("b_latch_clock_overlap", {31'b0, latch_b & dclk_b}, 32'd0);
        if (avail_b) avb_lat = cyc - rise_b;
        lp_b = latch_b;
        cp_b = dclk_b;
    end

    task automatic wait_avail_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (avail_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        bit   ok;
        int   n_av;
        vecs[0] = '{8'h09, 8'h00, 16'h0009, 2'b01};
        vecs[1] = '{8'h09, 8'h00, 16'h0009, 2'b00};
        vecs[2] = '{8'h09, 8'h80, 16'h8009, 2'b10};
        vecs[3] = '{8'hFF, 8'hFF, 16'hFFFF, 2'b11};
        vecs[4] = '{8'h00, 8'h00, 16'h0000, 2'b11};
        vecs[5] = '{8'hA5, 8'h5A, 16'h5AA5, 2'b11};
        vecs[6] = '{8'hA5, 8'h5B, 16'h5BA5, 2'b10};

        rst = 1'b1; trig = 1'b0; poll_en = 1'b0; trig_b = 1'b0;
        btn_a[0] = 8'h00; btn_a[1] = 8'h00; btn_b = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_button_state", {16'b0, state_a}, 32'd0);
        chk("rst_latch", {31'b0, latch_a}, 32'd0);
        chk("rst_clock", {31'b0, dclk_a}, 32'd0);
        chk("rst_available", {31'b0, avail_a}, 32'd0);
        chk("rst_changed", {30'b0, chg_a}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of triggered polls.
        for (int i = 0; i < 7; i++) begin
            btn_a[0] = vecs[i].pad0;
            btn_a[1] = vecs[i].pad1;
            sb.push_back('{vecs[i].st, vecs[i].chg});
            pulse_trig();
            wait_avail_a(200, ok);
            chk("vec_poll_done", {31'b0, ok}, 32'd1);
            repeat (20) @(negedge clk);
            chk("vec_hold", {16'b0, state_a}, {16'b0, vecs[i].st});
        end

        // Automatic polling every PC cycles.
        btn_a[0] = 8'h00; btn_a[1] = 8'h00;
        rise_log.delete();
        sb.push_back('{16'h0000, 2'b11});
        sb.push_back('{16'h0000, 2'b00});
        sb.push_back('{16'h0000, 2'b00});
        poll_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_avail_a(450, ok);
            chk("periodic_poll_done", {31'b0, ok}, 32'd1);
        end
        poll_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("periodic_rise_count", rise_log.size(), 32'd3);
        if (rise_log.size() >= 3) begin
            chk("periodic_interval_1", rise_log[1] - rise_log[0], PC);
            chk("periodic_interval_2", rise_log[2] - rise_log[1], PC);
        end

        // Trigger held through a whole poll: one poll, next starts right after.
        btn_a[0] = 8'h12; btn_a[1] = 8'h34;
        rise_log.delete();
        avail_log.delete();
        sb.push_back('{16'h3412, 2'b11});
        sb.push_back('{16'h3412, 2'b00});
        trig = 1'b1;
        wait_avail_a(200, ok);
        chk("held_first_done", {31'b0, ok}, 32'd1);
        @(negedge clk);
        trig = 1'b0;
        wait_avail_a(200, ok);
        chk("held_second_done", {31'b0, ok}, 32'd1);
        repeat (100) @(negedge clk);
        chk("held_rise_count", rise_log.size(), 32'd2);
        if (rise_log.size() >= 2 && avail_log.size() >= 1)
            chk("held_restart_gap", rise_log[1] - avail_log[0], 32'd1);

        // Reset during bit 4 discards the poll.
        btn_a[0] = 8'h09; btn_a[1] = 8'h00;
        rise_log.delete();
        avail_log.delete();
        pulse_trig();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pulses_a == 4 && !dclk_a) begin ok = 1'b1; break; end
        end
        chk("reset_reach_bit4", {31'b0, ok}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_button_state", {16'b0, state_a}, 32'd0);
        chk("async_rst_latch", {31'b0, latch_a}, 32'd0);
        chk("async_rst_clock", {31'b0, dclk_a}, 32'd0);
        chk("async_rst_available", {31'b0, avail_a}, 32'd0);
        chk("async_rst_changed", {30'b0, chg_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_av = avail_log.size();
        repeat (150) @(negedge clk);
        chk("reset_no_available", avail_log.size(), n_av);
        chk("reset_no_restart", rise_log.size(), 32'd1);
        chk("reset_state_stays_zero", {16'b0, state_a}, 32'd0);

        // First poll after reset compares against zero.
        sb.push_back('{16'h0009, 2'b01});
        pulse_trig();
        wait_avail_a(200, ok);
        chk("post_reset_poll_done", {31'b0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        // 16-bit single pad, bit 15 pressed.
        btn_b = 16'h8000;
        trig_b = 1'b1;
        @(negedge clk);
        trig_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (avail_b) begin ok = 1'b1; break; end
        end
        chk("b_poll_done", {31'b0, ok}, 32'd1);
        chk("b_button_state", {16'b0, state_b}, 32'h8000);
        chk("b_changed", {31'b0, chg_b}, 32'd1);
        chk("b_clock_pulses", pulses_b, 32'd15);
        @(negedge clk);
        chk("b_latency", avb_lat, LC + 31 * HC + 1);
        chk("b_changed_after", {31'b0, chg_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gamepad_poller.md
GAMEPAD_POLLER -- requirements
Module: gamepad_poller

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2: number of controller ports, 1..4, sharing one latch and one clock line.
REQ-002 SHALL have parameter NUM_BITS, default 8: bits read per poll, 8 for NES or 16 for SNES.
REQ-003 SHALL have parameter LATCH_CYCLES, default 324: latch high time in i_clk cycles, >=1.
REQ-004 SHALL have parameter HALF_CYCLES, default 162: data-clock half period in i_clk cycles, >=1.
REQ-005 SHALL have parameter POLL_CYCLES, default 450000: automatic poll period in i_clk cycles.
REQ-006 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_poll_en  input  1  enables automatic polling on poll-timer wrap.
REQ-009 SHALL have port i_trigger  input  1  requests an immediate poll.
REQ-010 SHALL have port o_data_latch  output  1  shared latch to all pads.
REQ-011 SHALL have port o_data_clock  output  1  shared data clock, idle low.
REQ-012 SHALL have port i_serial_data  input  NUM_PADS  per-pad serial data, active-low.
REQ-013 SHALL have port o_button_state  output  NUM_PADS*NUM_BITS  pressed=1; pad p bit k at index p*NUM_BITS+k.
REQ-014 SHALL have port o_data_available  output  1  one-cycle pulse when o_button_state updates.
REQ-015 SHALL have port o_changed  output  NUM_PADS  per-pad "word differs from previous poll", valid with o_data_available.

Function
REQ-016 SHALL implement states IDLE, LATCH, LOW, HIGH, DONE; every output registered.
REQ-017 Poll timer SHALL count 0..POLL_CYCLES-1 and wrap, free-running regardless of state.
REQ-018 Poll start SHALL occur in IDLE when i_trigger=1, or when timer wraps and i_poll_en=1; either starts one poll.
REQ-019 Start condition outside IDLE SHALL be dropped, not queued; poll in progress never restarts.
REQ-020 IDLE->LATCH: o_data_latch=1 from the next cycle for exactly LATCH_CYCLES cycles, o_data_clock=0.
REQ-021 LATCH->LOW for bit 0; LOW lasts HALF_CYCLES cycles with latch=0 and clock=0.
REQ-022 On the last LOW cycle, SHALL capture !i_serial_data[p] into bit k of every pad p's shadow word.
REQ-023 LOW->HIGH for k<NUM_BITS-1: o_data_clock=1 for HALF_CYCLES cycles, then LOW for bit k+1.
REQ-024 LOW->DONE after bit NUM_BITS-1 captured; no clock pulse follows the final bit.
REQ-025 DONE lasts one cycle: o_button_state<=shadow, o_data_available=1, o_changed[p]=(new word p != old word p); then IDLE.
REQ-026 o_changed SHALL be 0 in every cycle o_data_available=0.
REQ-027 Latch rise to o_data_available SHALL be LATCH_CYCLES + (2*NUM_BITS-1)*HALF_CYCLES + 1 cycles (69 for 8/4/8).
REQ-028 o_button_state SHALL hold between polls; no partial word ever visible.
REQ-029 o_data_latch and o_data_clock SHALL never be high simultaneously.
REQ-030 POLL_CYCLES SHALL exceed LATCH_CYCLES+2*NUM_BITS*HALF_CYCLES+2; violation is a configuration error.

Reset
REQ-031 i_rst=1 SHALL asynchronously force IDLE, poll timer 0, shadow 0, o_button_state 0, o_data_latch 0, o_data_clock 0, o_data_available 0, o_changed 0.
REQ-032 Reset mid-poll SHALL discard the partial poll; first poll after release occurs only by REQ-018.
REQ-033 First poll after reset SHALL compare against all-zero previous word.

Verification (NUM_PADS=2, NUM_BITS=8, LATCH_CYCLES=8, HALF_CYCLES=4, POLL_CYCLES=200)
REQ-034 i_trigger pulse, pad0 model presses A+Start, pad1 none -> latch 8 cycles, 7 clock pulses of 4, available 69 cycles after latch rise, o_button_state=16'h0009, o_changed=2'b01.
REQ-035 Repeat same stimulus -> o_button_state=16'h0009, o_changed=2'b00.
REQ-036 i_poll_en=1, no trigger, pads idle -> polls start every 200 cycles exactly, o_data_available one cycle each.
REQ-037 i_trigger held high throughout a poll -> exactly one poll completes, next starts the cycle after return to IDLE.
REQ-038 i_rst asserted during bit 4 of a poll -> all outputs 0 asynchronously, no o_data_available, o_button_state stays 0 after release.
REQ-039 NUM_BITS=16, NUM_PADS=1, pad presses bit 15 only -> o_button_state=16'h8000, 15 clock pulses observed.
